vga_sync_receiver: RTL
======================

Name: vga_sync_receiver

Overview:
- Receive-side counterpart of the team's VGA screen generator: consumes h_sync, v_sync and 1-bit r/g/b, recovers pixel coordinates, checks timing against the 640x480@60 frame format and locks.
- Drives captured pixels with x/y coordinates to a frame checker/scoreboard or capture buffer; also usable as an on-chip loopback monitor of the generator.

Parameters:
- PIX_DIV, 4, clk cycles per pixel (100 MHz clk -> 25 MHz pixel); 1 allowed.
- H_ACTIVE, 640, active pixels per line.
- H_SYNC, 96, h_sync low width in pixels.
- H_BP, 48, back porch in pixels.
- H_TOTAL, 800, pixels per line.
- V_ACTIVE, 480, active lines.
- V_SYNC, 2, v_sync low width in lines.
- V_BP, 33, back porch in lines.
- V_TOTAL, 525, lines per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- h_sync  in  1  horizontal sync, active low.
- v_sync  in  1  vertical sync, active low.
- r_in / g_in / b_in  in  1 each  colour bits.
- pix_valid  out  1  captured active-area pixel this cycle.
- pix_x  out  10  column 0..H_ACTIVE-1.
- pix_y  out  10  row 0..V_ACTIVE-1.
- pix_rgb  out  3  {r,g,b}.
- locked  out  1  timing verified.
- frame_done  out  1  one-cycle pulse at each frame boundary while locked.
- line_len  out  12  last measured line length in pixels.
- frame_lines  out  11  last measured frame length in lines.
- err_cnt  out  8  saturating timing-error count.
- frame_sum  out  16  active-pixel checksum (optional feature).

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM = SEARCH, all counters 0. Deassertion is taken synchronously through the first registered stage.
- Inputs registered once. Edges are detected on the registered copies.
- Pixel tick: divider counter 0..PIX_DIV-1. Forced to 0 on an h_sync falling edge, so a tick occurs on that cycle. All counting below happens on ticks only.
- hcnt (12b):
  - Set to 0 on h_sync fall; otherwise increments per tick.
  - On h_sync fall, line_len <= hcnt+1.
  - Low-pulse width is measured; rising edge with width != H_SYNC is an error.
- vcnt (11b):
  - Increments on h_sync fall.
  - Set to 0 on v_sync fall. If both edges coincide, v_sync wins and vcnt = 0.
  - On v_sync fall, frame_lines <= vcnt+1.
- Error events (each increments err_cnt, saturating at 255):
  - Line length mismatch: line_len != H_TOTAL, checked at each h_sync fall except the first after SEARCH.
  - frame_lines != V_TOTAL.
  - Bad h_sync pulse width.
  - Timeout: hcnt reaches 2*H_TOTAL with no h_sync fall; hcnt then holds.
- FSM:
  - SEARCH -> MEASURE on a v_sync fall.
  - MEASURE -> LOCKED at the next v_sync fall if no error occurred in that frame.
  - MEASURE -> MEASURE on that v_sync fall if an error occurred: restart the frame measurement.
  - LOCKED -> SEARCH on any error, in the cycle after detection.
  - locked = (state == LOCKED), registered.
- Capture:
  - Condition: LOCKED, tick, hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - When met: pix_valid=1 for one clk; pix_x = hcnt-(H_SYNC+H_BP); pix_y = vcnt-(V_SYNC+V_BP); pix_rgb = registered inputs.
  - Latency: 2 clk from pin to outputs.
  - Outside capture, pix_valid=0 and x/y/rgb hold their last values.
- frame_done pulses on a v_sync fall while LOCKED, and also on the SEARCH/MEASURE -> LOCKED transition edge.
- Reset mid-frame: immediate return to SEARCH; no partial-frame outputs.

Optional Feature:
- Macro: VGA_RX_FRAME_SUM_EN.
- With the macro defined:
  - 16-bit wrap-around accumulator adds {13'b0, pix_rgb} for every pix_valid.
  - At frame_done the accumulator is copied to frame_sum and cleared in the same cycle.
  - Also cleared on leaving LOCKED.
- Without it: frame_sum tied to 0 and no accumulator logic is present.

Test Plan:
- Nominal generator timing, PIX_DIV=4:
  - locked=1 at the 2nd v_sync fall.
  - 307200 pix_valid per frame.
  - First pixel (0,0), last pixel (639,479).
  - line_len=800, frame_lines=525, err_cnt=0.
- Solid colour rgb=3'b101 for a frame, with VGA_RX_FRAME_SUM_EN defined -> frame_sum = 307200*5 mod 65536 = 28672 at the next frame_done.
- One line lengthened to 801 pixels while locked -> err_cnt 0->1, locked falls in the next cycle, pix_valid stays 0 until re-lock two v_sync falls later.
- h_sync held high for 1700 pixels -> timeout error, SEARCH; recovery on resumed syncs.
- Simultaneous h_sync/v_sync fall -> vcnt=0, not 1. Also check h_sync pulse of 95 pixels -> err_cnt increments.
- rst pulsed low mid-frame at pixel (320,240) -> all outputs 0 asynchronously, locked again only after two v_sync falls.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates from h/v sync, checks the frame timing and locks.
// Define VGA_RX_FRAME_SUM_EN to add a per-frame checksum of captured pixels on frame_sum_o.
module vga_sync_receiver #(
   parameter int PIX_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_TOTAL  = 800,
   parameter int V_ACTIVE = 480,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_TOTAL  = 525
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        h_sync_i,
   input  logic        v_sync_i,
   input  logic        r_i,
   input  logic        g_i,
   input  logic        b_i,
   output logic        pix_valid_o,
   output logic [9:0]  pix_x_o,
   output logic [9:0]  pix_y_o,
   output logic [2:0]  pix_rgb_o,
   output logic        locked_o,
   output logic        frame_done_o,
   output logic [11:0] line_len_o,
   output logic [10:0] frame_lines_o,
   output logic [7:0]  err_cnt_o,
   output logic [15:0] frame_sum_o
);

   localparam int          DIV_W     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
   localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
   localparam logic [11:0] H_TMO     = 12'(2 * H_TOTAL);
   localparam logic [11:0] H_X0      = 12'(H_SYNC + H_BP);
   localparam logic [11:0] H_X1      = 12'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
   localparam logic [10:0] V_Y0      = 11'(V_SYNC + V_BP);
   localparam logic [10:0] V_Y1      = 11'(V_SYNC + V_BP + V_ACTIVE);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

   state_e      state_q;
   logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
   logic [2:0]  rgb_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [11:0] hcnt_q, hcnt_d, hcnt_inc, x_off;
   logic [10:0] vcnt_q, vcnt_d, vcnt_inc, y_off;
   logic        line_ok_q, frame_err_q, locked_q, frame_done_q;
   logic        pix_valid_q;
   logic [9:0]  pix_x_q, pix_y_q;
   logic [2:0]  pix_rgb_q;
   logic [11:0] line_len_q;
   logic [10:0] frame_lines_q;
   logic [7:0]  err_cnt_q;
   logic        h_fall, h_rise, v_fall, tick, cap;
   logic        err_line, err_pulse, err_frame, err_tmo, any_err;
   logic [2:0]  n_err;
   logic [8:0]  err_sum;

   assign h_fall   = hs_prev_q & ~hs_q;
   assign h_rise   = ~hs_prev_q & hs_q;
   assign v_fall   = vs_prev_q & ~vs_q;
   assign tick     = h_fall | (div_q == '0);
   assign hcnt_inc = hcnt_q + 12'd1;
   assign vcnt_inc = vcnt_q + 11'd1;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      div_d = div_q + DIV_W'(1);
      if (h_fall) div_d = DIV_W'(1 % PIX_DIV);
      else if (div_q == DIV_W'(PIX_DIV - 1)) div_d = '0;
      hcnt_d = hcnt_q;
      if (h_fall) hcnt_d = '0;
      else if (tick && hcnt_q != H_TMO) hcnt_d = hcnt_inc;
      vcnt_d = vcnt_q;
      if (v_fall) vcnt_d = '0;
      else if (h_fall) vcnt_d = vcnt_inc;
   end

   // line_ok_q is only set outside SEARCH, once a whole line/pulse has been timed from a fall.
   assign err_line  = h_fall & line_ok_q & (hcnt_inc != H_TOTAL_C);
   assign err_pulse = h_rise & line_ok_q & (hcnt_inc != H_SYNC_C);
   assign err_frame = v_fall & (state_q != SEARCH) & (vcnt_inc != V_TOTAL_C);
   assign err_tmo   = tick & ~h_fall & (state_q != SEARCH) & (hcnt_q == H_TMO - 12'd1);
   assign any_err   = err_line | err_pulse | err_frame | err_tmo;
   assign n_err     = {2'b0, err_line} + {2'b0, err_pulse} + {2'b0, err_frame} + {2'b0, err_tmo};
   assign err_sum   = {1'b0, err_cnt_q} + {6'b0, n_err};

   // Counters run one cycle ahead of the pixel data, so the next-state value names the pixel in rgb_q.
   assign cap   = (state_q == LOCKED) && tick && (hcnt_d >= H_X0) && (hcnt_d < H_X1)
                  && (vcnt_d >= V_Y0) && (vcnt_d < V_Y1);
   assign x_off = hcnt_d - H_X0;
   assign y_off = vcnt_d - V_Y0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         hs_prev_q     <= 1'b1;
         vs_prev_q     <= 1'b1;
         rgb_q         <= '0;
         div_q         <= '0;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         err_cnt_q     <= '0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_rgb_q     <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         hs_q      <= h_sync_i;
         vs_q      <= v_sync_i;
         hs_prev_q <= hs_q;
         vs_prev_q <= vs_q;
         rgb_q     <= {r_i, g_i, b_i};
         div_q     <= div_d;
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         if (h_fall) line_len_q <= hcnt_inc;
         if (v_fall) frame_lines_q <= vcnt_inc;
         if (any_err) err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
         pix_valid_q <= cap;
         if (cap) begin
            pix_x_q   <= x_off[9:0];
            pix_y_q   <= y_off[9:0];
            pix_rgb_q <= rgb_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= SEARCH;
         locked_q     <= 1'b0;
         frame_done_q <= 1'b0;
         line_ok_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            SEARCH: begin
               line_ok_q <= 1'b0;
               if (v_fall) begin
                  state_q     <= MEASURE;
                  frame_err_q <= 1'b0;
                  line_ok_q   <= h_fall;
               end
            end
            MEASURE: begin
               if (h_fall) line_ok_q <= 1'b1;
               if (v_fall) begin
                  frame_err_q <= 1'b0;
                  if (!(frame_err_q || any_err)) begin
                     state_q      <= LOCKED;
                     locked_q     <= 1'b1;
                     frame_done_q <= 1'b1;
                  end
               end else if (any_err) begin
                  frame_err_q <= 1'b1;
               end
            end
            LOCKED: begin
               frame_done_q <= v_fall;
               if (any_err) begin
                  state_q   <= SEARCH;
                  locked_q  <= 1'b0;
                  line_ok_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= SEARCH;
               locked_q  <= 1'b0;
               line_ok_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef VGA_RX_FRAME_SUM_EN
   logic [15:0] acc_q, frame_sum_q;
   logic        leave_lock;
   assign leave_lock = (state_q == LOCKED) && any_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q       <= '0;
         frame_sum_q <= '0;
      end else begin
         if (frame_done_q) frame_sum_q <= acc_q;
         if (frame_done_q || leave_lock) acc_q <= '0;
         else if (pix_valid_q) acc_q <= acc_q + {13'b0, pix_rgb_q};
      end
   end
   assign frame_sum_o = frame_sum_q;
`else
   assign frame_sum_o = 16'd0;
`endif

   assign pix_valid_o   = pix_valid_q;
   assign pix_x_o       = pix_x_q;
   assign pix_y_o       = pix_y_q;
   assign pix_rgb_o     = pix_rgb_q;
   assign locked_o      = locked_q;
   assign frame_done_o  = frame_done_q;
   assign line_len_o    = line_len_q;
   assign frame_lines_o = frame_lines_q;
   assign err_cnt_o     = err_cnt_q;

endmodule
